// File: rtl/core_types.sv
// Shared core types: MEM1 request struct, data-memory bridge FSM state and
// request register, and memory access-size encodings.
package core_types;

  localparam logic [2:0] MEM_TYPE_BYTE = 3'b000;
  localparam logic [2:0] MEM_TYPE_HALF = 3'b001;
  localparam logic [2:0] MEM_TYPE_WORD = 3'b010;

  typedef struct packed {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [2:0]  rd_type;
    logic [2:0]  wr_type;
  } mem_cache_struct;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [2:0]  rd_type;
    logic [2:0]  wr_type;
  } dmem_req_t;

endpackage

// File: rtl/dmem_bridge_store_buffer.sv
// Single-entry posted-store buffer for dmem_bridge; drains on the write
// channel and frees itself on the wr_req & wr_rdy handshake.
module dmem_store_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_addr,
  input  logic [3:0]  push_wstrb,
  input  logic [31:0] push_data,
  input  logic [2:0]  push_type,
  input  logic        wr_rdy,
  output logic        valid,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] data,
  output logic [2:0]  wr_type
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      addr    <= '0;
      wstrb   <= '0;
      data    <= '0;
      wr_type <= '0;
    end else if (push) begin
      valid   <= 1'b1;
      addr    <= push_addr;
      wstrb   <= push_wstrb;
      data    <= push_data;
      wr_type <= push_type;
    end else if (valid && wr_rdy) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// Uncached data-memory responder: one MEM1 request at a time, turned into a
// single-beat rd/wr bus transaction. Optional posted store: DMEM_STORE_BUFFER_EN.
module dmem_bridge
  import core_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  mem_cache_struct signal_cache_i,
  output logic            cache_ack,
  output logic [31:0]     rdata_o,
  output logic            rdata_valid_o,
  output logic            rd_req,
  output logic [2:0]      rd_type,
  output logic [31:0]     rd_addr,
  input  logic            rd_rdy,
  input  logic            ret_valid,
  input  logic            ret_last,
  input  logic [31:0]     ret_data,
  output logic            wr_req,
  output logic [2:0]      wr_type,
  output logic [31:0]     wr_addr,
  output logic [3:0]      wr_wstrb,
  output logic [31:0]     wr_data,
  input  logic            wr_rdy
);

  dmem_state_t state, state_nxt;
  dmem_req_t   req;
  logic [31:0] rdata_q;
  logic        accept;
  logic        ack;
  logic        sb_push;
  logic        sb_valid;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sb_push   = 1'b0;
    ack       = 1'b0;
    case (state)
      IDLE: begin
        if (signal_cache_i.ce) begin
`ifdef DMEM_STORE_BUFFER_EN
          // Loads wait for the buffer to drain so they observe the posted store.
          if (signal_cache_i.we) begin
            if (!sb_valid) sb_push = 1'b1;
            else           ack     = 1'b1;
          end else if (sb_valid) begin
            ack = 1'b1;
          end else begin
            ack       = 1'b1;
            accept    = 1'b1;
            state_nxt = RD_REQ;
          end
`else
          ack       = 1'b1;
          accept    = 1'b1;
          state_nxt = signal_cache_i.we ? WR_REQ : RD_REQ;
`endif
        end
      end
      RD_REQ: begin
        ack = 1'b1;
        if (rd_rdy) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        ack = 1'b1;
        if (ret_valid && ret_last) state_nxt = DONE;
      end
      WR_REQ: begin
        ack = 1'b1;
        if (wr_rdy) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req.we      <= signal_cache_i.we;
        req.addr    <= signal_cache_i.addr;
        req.sel     <= signal_cache_i.sel;
        req.data    <= signal_cache_i.data;
        req.rd_type <= signal_cache_i.rd_type;
        req.wr_type <= signal_cache_i.wr_type;
      end
      if (state == RD_WAIT && ret_valid && ret_last) rdata_q <= ret_data;
    end
  end

  // ce can be high while rst is asserted; keep the stall low during reset.
  assign cache_ack     = ack & ~rst;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state == DONE) && !req.we;
  assign rd_req        = (state == RD_REQ);
  assign rd_addr       = req.addr;
  assign rd_type       = req.rd_type;

`ifdef DMEM_STORE_BUFFER_EN
  dmem_store_buffer u_store_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (sb_push),
    .push_addr  (signal_cache_i.addr),
    .push_wstrb (signal_cache_i.sel),
    .push_data  (signal_cache_i.data),
    .push_type  (signal_cache_i.wr_type),
    .wr_rdy     (wr_rdy),
    .valid      (sb_valid),
    .addr       (wr_addr),
    .wstrb      (wr_wstrb),
    .data       (wr_data),
    .wr_type    (wr_type)
  );
  assign wr_req = sb_valid;
`else
  assign sb_valid = 1'b0;
  assign wr_req   = (state == WR_REQ);
  assign wr_addr  = req.addr;
  assign wr_wstrb = req.sel;
  assign wr_data  = req.data;
  assign wr_type  = req.wr_type;
`endif

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Responder for the data-memory request port driven by the MEM1 stage. It accepts one `mem_cache_struct` request at a time (`ce`, `we`, `addr`, `sel`, `data`, `rd_type`, `wr_type`) and stalls MEM1 through `cache_ack` while the access is in flight. It converts each request into a single-beat transaction on the cache-style rd/wr memory bus and returns load data to MEM2. It sits between MEM1/MEM2 and the AXI bridge, and serves as the uncached data path.

## Interface
- No parameters. Bus widths are fixed at 32 bits.
- `clk` in 1: core clock.
- `rst` in 1: reset, asynchronous and active-high.
- `signal_cache_i` in `mem_cache_struct`: request from MEM1. Valid when `ce` is 1; `we` set means store.
- `cache_ack` out 1: busy. MEM1 stalls while `cache_ack & ce`.
- `rdata_o` out 32: raw load word, unaligned, no sign extension.
- `rdata_valid_o` out 1: one-cycle pulse with `rdata_o`.
- `rd_req` out 1, `rd_type` out 3, `rd_addr` out 32, `rd_rdy` in 1: read request channel.
- `ret_valid` in 1, `ret_last` in 1, `ret_data` in 32: read return channel.
- `wr_req` out 1, `wr_type` out 3, `wr_addr` out 32, `wr_wstrb` out 4, `wr_data` out 32, `wr_rdy` in 1: write channel.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE, `ce=1`:
  - Capture `addr`, `sel`, `data` and `rd_type`/`wr_type` into the request register.
  - Go to WR_REQ if `we`, otherwise RD_REQ.
- RD_REQ:
  - `rd_req=1`; `rd_addr`/`rd_type` come from the request register.
  - On `rd_rdy`, go to RD_WAIT.
- RD_WAIT:
  - On `ret_valid & ret_last`, latch `ret_data` and go to DONE.
  - Beats without `ret_last` are ignored.
- WR_REQ:
  - `wr_req=1`; `wr_wstrb=sel`, `wr_data=data`, `wr_addr=addr`.
  - On `wr_rdy`, go to DONE.
- DONE:
  - `cache_ack=0`. `rdata_valid_o=1` if the completed access was a load.
  - `ce` is ignored in this cycle, because it is the same MEM1 request that is now advancing.
  - Always return to IDLE.
- `cache_ack = (state!=IDLE && state!=DONE) || (state==IDLE && ce)`. This is combinational, so MEM1 stalls in the accept cycle.
- Request outputs hold stable while waiting for `rd_rdy`/`wr_rdy`. `rd_req` and `wr_req` are never high in the same cycle.
- `rdata_o` holds its last value between pulses.
- Reset (asynchronous, any state): state=IDLE. All outputs 0 immediately, including `cache_ack`, `rdata_o`, `rd_req` and `wr_req`. Any in-flight request and any buffered store are dropped.

## Timing
- Load, zero-wait bus:
  - T0: accept.
  - T1: `rd_req` with `rd_rdy`.
  - T2: `ret_valid`/`ret_last`.
  - T3: DONE, `rdata_valid_o=1`, `cache_ack=0`.
  - Total: 3 cycles of `cache_ack` (T0–T2).
- Store, zero-wait bus: T0 accept, T1 `wr_req` with `wr_rdy`, T2 DONE.
- Back-to-back requests: a new request can be accepted in the cycle after DONE. Throughput is 1 load per 4 cycles minimum.
- Wait states on `rd_rdy`, `ret_valid` or `wr_rdy` extend the matching state by one cycle each.

## Configuration
- `DMEM_STORE_BUFFER_EN` defined:
  - A store accepted in IDLE with an empty 1-entry store buffer is written into the buffer. `cache_ack` stays 0, so the store is posted with zero stall.
  - The buffer drains on the write channel independently of the FSM. It is freed on `wr_req & wr_rdy`.
  - A store while the buffer is full stalls (`cache_ack=1`) until the buffer frees, then is posted.
  - A load while the buffer is full stalls until the buffer drains, then proceeds as RD_REQ. This preserves load-after-store ordering.
- Undefined: every store takes the WR_REQ→DONE path described above.

## Structure
- Add to `core_types`:
  - the `dmem_state_t` enum;
  - the `dmem_req_t` request-register struct;
  - constants `MEM_TYPE_BYTE=3'b000`, `MEM_TYPE_HALF=3'b001`, `MEM_TYPE_WORD=3'b010`.
- Sub-module `dmem_store_buffer`: 1-entry buffer with valid, addr, wstrb, data and type, plus the drain handshake. Instantiate it only under `DMEM_STORE_BUFFER_EN`.

## Test plan
- Load word:
  - Stimulus: `ce=1, we=0, addr=0x1C00_0104, rd_type=010`; bus returns `0xDEADBEEF` with zero wait.
  - Required: `rd_addr=0x1C00_0104`, `rd_type=010`; `rdata_valid_o` pulses in T3 with `0xDEADBEEF`; `cache_ack` high T0–T2 only.
- Byte store:
  - Stimulus: `we=1, addr=0x8000_0003, sel=1000, data=0x5A5A5A5A, wr_type=000`; `wr_rdy` held low 3 cycles.
  - Required: `wr_req` stays high with stable fields for 4 cycles; `wr_wstrb=1000`; no `rdata_valid_o`.
- Held request:
  - Stimulus: `ce` held high through DONE, then dropped.
  - Required: exactly one `rd_req` handshake; no second accept.
- Multi-beat return:
  - Stimulus: `ret_valid` with `ret_last=0` data `0x1111`, then `ret_last=1` data `0x2222`.
  - Required: `rdata_o=0x2222`.
- Reset mid-operation:
  - Stimulus: `rst` pulse while in RD_WAIT.
  - Required: all outputs 0 in the same cycle; IDLE afterwards; a late `ret_valid` is ignored.
- `DMEM_STORE_BUFFER_EN`:
  - Stimulus: store, then load on the next cycle; `wr_rdy` delayed 2 cycles.
  - Required: store sees `cache_ack=0`; load stalls until the buffer drains; `rd_req` rises only after the `wr_req & wr_rdy` cycle.
